banco_registro_param: RTL and testbench
=======================================

Name: banco_registro_param

Overview:
- Parametrised, clocked successor to the combinational register bank.
- Provides two combinational read ports and one synchronous write port, with optional write-to-read bypass and an optional hardwired-zero register 0.
- Adds a sequential bulk-clear engine that zeroes the whole array, one register per cycle.
- Sits between the decode stage (register addresses) and the ALU/writeback path of the datapath.

Parameters:
- DATA_W, 32, width of each register and of di/DR1/DR2.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is an ordinary register.
- BYPASS, 1, 1 = same-cycle write data is forwarded to a matching read port; 0 = reads show array contents only.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- RA1  in  ADDR_W  read address, port 1.
- RA2  in  ADDR_W  read address, port 2.
- DR1  out  DATA_W  read data, port 1 (combinational).
- DR2  out  DATA_W  read data, port 2 (combinational).
- dir  in  ADDR_W  write address.
- di  in  DATA_W  write data.
- RW  in  1  write enable, sampled at posedge clk.
- clr  in  1  bulk-clear request, sampled at posedge clk.
- busy  out  1  registered; high while the clear engine runs.
- wr_drop  out  1  registered one-cycle pulse; a write was rejected.

Behaviour:
- Reset: one clock, reset asynchronous active-high.
  - rst=1 immediately forces all DEPTH registers to 0, FSM to IDLE, clear pointer to 0, busy=0, wr_drop=0.
  - DR1/DR2 therefore read 0 during reset.
- Write path:
  - In IDLE, when RW=1 at posedge: mem[dir] <= di.
  - If ZERO_REG=1 and dir==0, the write is discarded silently. It does not raise wr_drop.
- Read path: combinational, zero latency.
  - DRn = 0 if ZERO_REG=1 and RAn==0.
  - Else DRn = di if BYPASS=1, state==IDLE, RW=1 and dir==RAn.
  - Else DRn = mem[RAn].
  - Both ports may address the same register; both return identical data.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR: clr=1 at posedge. Then ptr <= 0 and busy <= 1.
  - A simultaneous RW=1 in the same edge is still performed, then overwritten when the clear reaches that address.
  - CLEAR, each posedge: mem[ptr] <= 0, ptr <= ptr+1.
  - CLEAR -> IDLE: when ptr == DEPTH-1 is written; busy <= 0 on that edge.
  - busy is high for exactly DEPTH cycles; ptr wraps to 0.
  - clr asserted while in CLEAR: ignored, no restart.
  - RW=1 in CLEAR: write ignored, bypass disabled, wr_drop=1 on the next cycle for one cycle per rejected write.
  - Reads during CLEAR return array contents as they stand: registers below ptr read 0, the rest keep their old values.
- Reset mid-clear: array zeroed, IDLE, busy=0 immediately; no residual operation afterwards.
- Width rules:
  - No arithmetic on data.
  - ptr is ADDR_W bits wide, with the terminal compare against all-ones.
  - Addresses are always in range, since DEPTH = 2**ADDR_W.
- No X ever propagates from the array: all entries are defined from reset onward, with no $readmemb dependency.

Test Plan:
- Reset then read: rst pulse, RA1=3, RA2=31 -> DR1=0, DR2=0.
- Write then read: RW=1, dir=5, di=32'hDEADBEEF, one edge; RW=0, RA1=5 -> DR1=32'hDEADBEEF. RA2=6 -> DR2=0.
- Bypass: RW=1, dir=7, di=32'h12345678, RA1=7 before the edge.
  - BYPASS=1 -> DR1=32'h12345678 combinationally.
  - BYPASS=0 -> DR1=old value, 0.
- Zero register (ZERO_REG=1): RW=1, dir=0, di=32'hFFFFFFFF; then RA1=0 -> DR1=0 and wr_drop stays 0.
- Bulk clear (ADDR_W=5):
  - Preload r1..r31 = index value; pulse clr.
  - busy high for exactly 32 cycles.
  - After 10 cycles, RA1=9 -> 0 and RA2=20 -> 20.
  - After busy falls, every register reads 0.
  - RW=1 during busy -> wr_drop pulse next cycle; the target stays 0.
- Reset mid-clear: clr, wait 4 cycles, assert rst asynchronously between edges -> busy=0 immediately, all reads 0. A subsequent write dir=2, di=32'hA5 is accepted: DR1=32'hA5 with RA1=2.

Source files
------------

// File: rtl/banco_registro_param.sv
// Parametrised register bank: two combinational read ports, one synchronous write port,
// optional write-to-read bypass, optional hardwired-zero r0, and a one-register-per-cycle bulk clear.
module banco_registro_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] DR1,
    output logic [DATA_W-1:0] DR2,
    input  logic [ADDR_W-1:0] dir,
    input  logic [DATA_W-1:0] di,
    input  logic              RW,
    input  logic              clr,
    output logic              busy,
    output logic              wr_drop
);

    localparam int DEPTH = 2**ADDR_W;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wr_drop_q, wr_drop_d;
    logic              idle;
    logic              wr_en;

    assign idle  = (state_q == S_IDLE);
    // Writes to a hardwired r0 vanish without counting as a rejected write.
    assign wr_en = idle && RW && !((ZERO_REG != 0) && (dir == '0));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_drop_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                ptr_d     = ptr_q + 1'b1;
                wr_drop_d = RW;
                if (ptr_q == '1)
                    state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Write and clear never collide: writes are only taken in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            if (wr_en)
                mem_q[dir] <= di;
            if (state_q == S_CLEAR)
                mem_q[ptr_q] <= '0;
        end
    end

    logic [1:0][ADDR_W-1:0] ra;
    logic [1:0][DATA_W-1:0] dr;

    assign ra = {RA2, RA1};

    always_comb begin
        dr = '0;
        for (int p = 0; p < 2; p++) begin
            if ((ZERO_REG != 0) && (ra[p] == '0))
                dr[p] = '0;
            else if ((BYPASS != 0) && idle && RW && (dir == ra[p]))
                dr[p] = di;
            else
                dr[p] = mem_q[ra[p]];
        end
    end

    assign DR1     = dr[0];
    assign DR2     = dr[1];
    assign busy    = (state_q == S_CLEAR);
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_banco_registro_param.sv
// Directed bench for banco_registro_param: default build (bypass, zero r0) plus a
// plain build (no bypass, ordinary r0) driven by the same inputs.
module tb_banco_registro_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  RA1, RA2, dir;
    logic [31:0] di;
    logic        RW, clr;
    logic [31:0] DR1, DR2, b_DR1, b_DR2;
    logic        busy, wr_drop, b_busy, b_wr_drop;

    int n_chk  = 0;
    int n_fail = 0;
    int busy_cycles;

    always #5 clk = ~clk;

    banco_registro_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .RA1(RA1), .RA2(RA2), .DR1(DR1), .DR2(DR2),
        .dir(dir), .di(di), .RW(RW), .clr(clr), .busy(busy), .wr_drop(wr_drop)
    );

    banco_registro_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst), .RA1(RA1), .RA2(RA2), .DR1(b_DR1), .DR2(b_DR2),
        .dir(dir), .di(di), .RW(RW), .clr(clr), .busy(b_busy), .wr_drop(b_wr_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; RA1 = 5'd3; RA2 = 5'd31; dir = '0; di = '0; RW = 1'b0; clr = 1'b0;
        #2;
        chk("reset_dr1", DR1, 32'h0);
        chk("reset_dr2", DR2, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_wr_drop", {31'b0, wr_drop}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_reset_dr2", DR2, 32'h0);

        // plain write then read
        RW = 1'b1; dir = 5'd5; di = 32'hDEADBEEF;
        tick();
        RW = 1'b0; RA1 = 5'd5; RA2 = 5'd6;
        #1;
        chk("write_read_dr1", DR1, 32'hDEADBEEF);
        chk("write_read_dr2", DR2, 32'h0);
        chk("write_read_nb_dr1", b_DR1, 32'hDEADBEEF);

        // bypass on the same cycle as the write
        RW = 1'b1; dir = 5'd7; di = 32'h12345678; RA1 = 5'd7;
        #1;
        chk("bypass_dr1", DR1, 32'h12345678);
        chk("no_bypass_dr1", b_DR1, 32'h0);
        tick();
        RW = 1'b0;
        #1;
        chk("bypass_after_edge", DR1, 32'h12345678);
        chk("no_bypass_after_edge", b_DR1, 32'h12345678);

        // register 0
        RW = 1'b1; dir = 5'd0; di = 32'hFFFFFFFF; RA1 = 5'd0;
        #1;
        chk("zero_reg_bypass", DR1, 32'h0);
        tick();
        RW = 1'b0;
        #1;
        chk("zero_reg_read", DR1, 32'h0);
        chk("zero_reg_no_drop", {31'b0, wr_drop}, 32'h0);
        chk("plain_r0_read", b_DR1, 32'hFFFFFFFF);
        tick();
        chk("zero_reg_no_drop_2", {31'b0, wr_drop}, 32'h0);

        // preload r1..r31 with their own index
        for (int i = 1; i < 32; i++) begin
            RW = 1'b1; dir = 5'(i); di = 32'(i);
            tick();
        end
        RW = 1'b0; RA1 = 5'd31; RA2 = 5'd5;
        #1;
        chk("preload_r31", DR1, 32'd31);
        chk("preload_r5", DR2, 32'd5);

        // bulk clear
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clear_busy_rise", {31'b0, busy}, 32'h1);
        chk("clear_busy_nb", {31'b0, b_busy}, 32'h1);
        busy_cycles = 1;
        for (int c = 1; c <= 40; c++) begin
            if (c == 13) begin
                RW = 1'b1; dir = 5'd3; di = 32'h0000AAAA; RA1 = 5'd3;
                #1;
                chk("clear_bypass_off", DR1, 32'h0);
            end
            tick();
            if (busy) busy_cycles++;
            if (c == 10) begin
                RA1 = 5'd9; RA2 = 5'd20;
                #1;
                chk("clear_mid_r9", DR1, 32'h0);
                chk("clear_mid_r20", DR2, 32'd20);
            end
            if (c == 13) begin
                RW = 1'b0;
                chk("clear_wr_drop", {31'b0, wr_drop}, 32'h1);
                chk("clear_wr_drop_nb", {31'b0, b_wr_drop}, 32'h1);
            end
            if (c == 14) begin
                chk("clear_wr_drop_fall", {31'b0, wr_drop}, 32'h0);
                #1;
                chk("clear_target_zero", DR1, 32'h0);
            end
            if (!busy) break;
        end
        chk("clear_busy_cycles", 32'(busy_cycles), 32'd32);
        chk("clear_busy_fall", {31'b0, busy}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            RA1 = 5'(i); RA2 = 5'(31 - i);
            #1;
            chk("cleared_dr1", DR1, 32'h0);
            chk("cleared_nb_dr2", b_DR2, 32'h0);
        end

        // reset in the middle of a clear
        tick();
        RW = 1'b1; dir = 5'd25; di = 32'd55;
        tick();
        RW = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        RA1 = 5'd25; RA2 = 5'd2;
        #1;
        chk("midclr_busy", {31'b0, busy}, 32'h1);
        chk("midclr_r25_kept", DR1, 32'd55);
        #1;
        rst = 1'b1;
        #1;
        chk("midclr_rst_busy", {31'b0, busy}, 32'h0);
        chk("midclr_rst_r25", DR1, 32'h0);
        chk("midclr_rst_nb_r25", b_DR1, 32'h0);
        #2;
        rst = 1'b0;
        tick();
        chk("after_rst_busy", {31'b0, busy}, 32'h0);
        RW = 1'b1; dir = 5'd2; di = 32'hA5;
        tick();
        RW = 1'b0; RA1 = 5'd2;
        #1;
        chk("after_rst_write", DR1, 32'hA5);
        for (int c = 0; c < 3; c++) tick();
        chk("after_rst_hold", DR1, 32'hA5);
        chk("after_rst_idle", {31'b0, busy}, 32'h0);
        chk("after_rst_no_drop", {31'b0, wr_drop}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
